rect_rasterizer: RTL and testbench
==================================

# rect_rasterizer

Command-driven rectangle rasterizer in the `clk_33m` domain, directly upstream of the VGA frame-buffer block. It accepts filled-rectangle draw commands through a valid/ready queue and clips them to the 1280×300 drawable frame. It emits one pixel per cycle on `write_x`/`write_y`/`write_palette`, which drive the VGA block's write port. It tracks the frame-swap signal `rst_screen_33m`: it stalls while the swap is active, discards unfinished work at swap start, and pulses `frame_start` when the new write half is ready.

## Interface
- `COOR_WIDTH`, 11: coordinate/size width.
- `FRAME_W`, 1280: drawable width; valid x is [0, FRAME_W).
- `FRAME_H`, 300: drawable height; valid y is [0, FRAME_H).
- `FIFO_DEPTH`, 8: command queue entries (power of 2).

Ports:
- `clk_33m`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rst_screen_33m`  in  1  frame-swap window from the VGA block, synchronous to `clk_33m`.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  queue can accept.
- `cmd_x`, `cmd_y`  in  COOR_WIDTH  top-left corner.
- `cmd_w`, `cmd_h`  in  COOR_WIDTH  width and height in pixels.
- `cmd_palette`  in  2  fill colour index; 0 means no-op.
- `write_x`  out  COOR_WIDTH  pixel x, registered.
- `write_y`  out  COOR_WIDTH  pixel y, registered.
- `write_palette`  out  2  pixel colour, registered; 0 means no write this cycle.
- `busy`  out  1  state is not IDLE, or the queue is non-empty.
- `frame_start`  out  1  one-cycle pulse when a swap window ends.
- `overrun`  out  1  sticky; set when a swap discards pending work.

## Operation
- Queue: synchronous FIFO of {x, y, w, h, palette}.
  - `cmd_ready = !full && !rst_screen_33m`.
  - A push happens on any edge where `cmd_valid && cmd_ready`.
- FSM has three states: IDLE, LOAD, DRAW.
- IDLE: if the queue is non-empty, pop the head and go to LOAD.
- LOAD: clip the command, then either drop it or start drawing.
  - Clip: `x_end = min(x + w, FRAME_W)` and `y_end = min(y + h, FRAME_H)`, both computed at COOR_WIDTH+1 bits with no overflow.
  - Drop (return to IDLE) if `x >= FRAME_W`, `y >= FRAME_H`, `w == 0`, `h == 0`, or `palette == 0`.
  - Otherwise set cursor `(cx, cy) = (x, y)` and go to DRAW.
- DRAW: emit `(cx, cy, palette)` each cycle, scanning row-major.
  - When `cx == x_end-1`: set `cx = x`, `cy++`.
  - After pixel `(x_end-1, y_end-1)`, go to IDLE.
- Outputs: `write_palette` = 0 in every cycle not emitting a pixel (IDLE, LOAD, stall). `write_x`/`write_y` hold their last values in those cycles.
- Stall: while `rst_screen_33m` = 1, DRAW does not advance the cursor, the queue does not pop, and `write_palette` = 0.
- Swap start: `rise = rst_screen_33m && !rst_screen_q`, where `rst_screen_q` is `rst_screen_33m` registered.
  - On `rise`: flush the queue and force IDLE.
  - If the state was LOAD/DRAW or the queue was non-empty, set `overrun`.
- Swap end: `frame_start` = `!rst_screen_33m && rst_screen_q`, registered. The source resubmits the full scene after this pulse.
- `overrun` clears only on reset.

## Timing
- Reset values:
  - outputs: `write_x` = 0, `write_y` = 0, `write_palette` = 0, `busy` = 0, `frame_start` = 0, `overrun` = 0;
  - internal: queue empty, state IDLE, `rst_screen_q` = 0;
  - `cmd_ready` = 1 once `rst_n` deasserts, if `rst_screen_33m` = 0.
- Latency, with an empty queue in IDLE and the command accepted on edge N:
  - pop on edge N+1 (enter LOAD);
  - DRAW entered on edge N+2;
  - first pixel registered on edge N+3.
- Throughput: one pixel per cycle inside a rectangle. Exactly 2 cycles with `write_palette` = 0 between the last pixel of one command and the first pixel of the next queued command (IDLE + LOAD).
- Dropped commands: cost 2 cycles and produce no pixels.
- Full queue: `cmd_ready` = 0. A simultaneous pop and push when full is not possible, because ready is computed from `full` before the pop.
- Push and `rise` in the same cycle: cannot occur, because `cmd_ready` = 0 whenever `rst_screen_33m` = 1.
- Reset asserted mid-DRAW: all state returns to reset values immediately (asynchronous).

## Test plan
- Queue one command `x=10, y=20, w=3, h=2, pal=2` with `rst_screen_33m` = 0.
  - Expect 6 pixels (10..12, 20), then (10..12, 21), consecutive, first pixel at N+3.
  - Then `write_palette` = 0 and `busy` = 0.
- Queue `x=1278, y=299, w=5, h=5, pal=1`.
  - Expect exactly 2 pixels: (1278, 299) and (1279, 299).
- Queue `w=0`, `pal=0`, and `x=1300` commands back to back, then a valid `x=0, y=0, w=1, h=1, pal=3`.
  - Expect only (0, 0, 3), first pixel at edge 9 after the first accept.
- Push 9 commands back-to-back while a large rectangle draws.
  - `cmd_ready` falls after 8 accepted.
  - All commands are drawn in order with 2 idle cycles between them.
- Raise `rst_screen_33m` for 5 cycles mid-rectangle with 3 commands queued.
  - `write_palette` = 0 during the window; queue empties; `overrun` = 1.
  - `frame_start` pulses exactly once, 1 cycle after the fall.
- Assert `rst_n` low mid-DRAW.
  - All outputs read reset values while low.
  - The next command after release starts from IDLE with N+3 latency.

Source files
------------

// File: rtl/rect_rasterizer.sv
// Filled-rectangle rasterizer: queues draw commands, clips them to the drawable frame
// and streams one pixel per cycle into the VGA frame-buffer write port.
module rect_rasterizer #(
   parameter int COOR_WIDTH = 11,
   parameter int FRAME_W    = 1280,
   parameter int FRAME_H    = 300,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk_33m,
   input  logic                  rst_n,
   input  logic                  rst_screen_33m,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [COOR_WIDTH-1:0] cmd_x,
   input  logic [COOR_WIDTH-1:0] cmd_y,
   input  logic [COOR_WIDTH-1:0] cmd_w,
   input  logic [COOR_WIDTH-1:0] cmd_h,
   input  logic [1:0]            cmd_palette,
   output logic [COOR_WIDTH-1:0] write_x,
   output logic [COOR_WIDTH-1:0] write_y,
   output logic [1:0]            write_palette,
   output logic                  busy,
   output logic                  frame_start,
   output logic                  overrun
);
   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam int CMD_W  = 4 * COOR_WIDTH + 2;
   localparam int EXT_W  = COOR_WIDTH + 1;
   localparam logic [EXT_W-1:0]      FRAME_W_EXT = EXT_W'(FRAME_W);
   localparam logic [EXT_W-1:0]      FRAME_H_EXT = EXT_W'(FRAME_H);
   localparam logic [EXT_W-1:0]      EXT_ONE     = EXT_W'(1);
   localparam logic [PTR_W-1:0]      PTR_ONE     = PTR_W'(1);
   localparam logic [COOR_WIDTH-1:0] COOR_ONE    = COOR_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;
   state_t state;

   logic [CMD_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push;
   logic                  pop;
   logic                  rst_screen_q;
   logic                  rise;

   logic [COOR_WIDTH-1:0] cur_x;
   logic [COOR_WIDTH-1:0] cur_y;
   logic [COOR_WIDTH-1:0] cur_w;
   logic [COOR_WIDTH-1:0] cur_h;
   logic [1:0]            cur_pal;
   logic [COOR_WIDTH-1:0] cx;
   logic [COOR_WIDTH-1:0] cy;
   logic [EXT_W-1:0]      x_end;
   logic [EXT_W-1:0]      y_end;
   logic [EXT_W-1:0]      x_sum;
   logic [EXT_W-1:0]      y_sum;
   logic [EXT_W-1:0]      x_end_clip;
   logic [EXT_W-1:0]      y_end_clip;
   logic                  drop;
   logic                  last_col;
   logic                  last_row;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr == {~rd_ptr[ADDR_W], rd_ptr[ADDR_W-1:0]});
   assign cmd_ready  = !fifo_full && !rst_screen_33m;
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == IDLE) && !fifo_empty && !rst_screen_33m;
   assign rise       = rst_screen_33m && !rst_screen_q;
   assign busy       = (state != IDLE) || !fifo_empty;

   // One extra bit keeps x+w and y+h from wrapping before the clip
   assign x_sum      = {1'b0, cur_x} + {1'b0, cur_w};
   assign y_sum      = {1'b0, cur_y} + {1'b0, cur_h};
   assign x_end_clip = (x_sum > FRAME_W_EXT) ? FRAME_W_EXT : x_sum;
   assign y_end_clip = (y_sum > FRAME_H_EXT) ? FRAME_H_EXT : y_sum;
   assign drop       = ({1'b0, cur_x} >= FRAME_W_EXT) || ({1'b0, cur_y} >= FRAME_H_EXT) ||
                       (cur_w == '0) || (cur_h == '0) || (cur_pal == 2'd0);

   assign last_col   = (({1'b0, cx} + EXT_ONE) == x_end);
   assign last_row   = (({1'b0, cy} + EXT_ONE) == y_end);

   always_ff @(posedge clk_33m) begin
      if (push) begin
         fifo_mem[wr_ptr[ADDR_W-1:0]] <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_palette};
      end
   end

   always_ff @(posedge clk_33m) begin
      if (pop) begin
         {cur_x, cur_y, cur_w, cur_h, cur_pal} <= fifo_mem[rd_ptr[ADDR_W-1:0]];
      end
      if (!rst_screen_33m) begin
         if (state == LOAD) begin
            cx    <= cur_x;
            cy    <= cur_y;
            x_end <= x_end_clip;
            y_end <= y_end_clip;
         end else if (state == DRAW) begin
            if (last_col) begin
               cx <= cur_x;
               cy <= cy + COOR_ONE;
            end else begin
               cx <= cx + COOR_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk_33m or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         rst_screen_q  <= 1'b0;
         frame_start   <= 1'b0;
         overrun       <= 1'b0;
         write_x       <= '0;
         write_y       <= '0;
         write_palette <= 2'd0;
      end else begin
         rst_screen_q  <= rst_screen_33m;
         frame_start   <= !rst_screen_33m && rst_screen_q;
         write_palette <= 2'd0;
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rise) begin
            // Swap start abandons everything; the source resubmits the whole scene
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
            if ((state != IDLE) || !fifo_empty) begin
               overrun <= 1'b1;
            end
         end else if (!rst_screen_33m) begin
            case (state)
               IDLE: begin
                  if (!fifo_empty) begin
                     rd_ptr <= rd_ptr + PTR_ONE;
                     state  <= LOAD;
                  end
               end
               LOAD: begin
                  state <= drop ? IDLE : DRAW;
               end
               DRAW: begin
                  write_x       <= cx;
                  write_y       <= cy;
                  write_palette <= cur_pal;
                  if (last_col && last_row) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rect_rasterizer.sv
// Bench for rect_rasterizer: directed scenarios plus randomized commands and swap windows,
// checked every cycle against a command-queue / pixel-list reference model.
module tb_rect_rasterizer;
   localparam int CW = 11;

   typedef struct packed { logic [CW-1:0] x; logic [CW-1:0] y; logic [CW-1:0] w; logic [CW-1:0] h; logic [1:0] pal; } cmd_t;
   typedef struct packed { logic [CW-1:0] x; logic [CW-1:0] y; logic [1:0] pal; } pix_t;
   typedef struct { int x; int y; int pal; int cyc; } log_t;

   logic          clk_33m = 1'b0;
   logic          rst_n = 1'b0;
   logic          rst_screen_33m = 1'b0;
   logic          cmd_valid = 1'b0;
   logic [CW-1:0] cmd_x = '0;
   logic [CW-1:0] cmd_y = '0;
   logic [CW-1:0] cmd_w = '0;
   logic [CW-1:0] cmd_h = '0;
   logic [1:0]    cmd_palette = 2'd0;
   logic          cmd_ready;
   logic [CW-1:0] write_x;
   logic [CW-1:0] write_y;
   logic [1:0]    write_palette;
   logic          busy;
   logic          frame_start;
   logic          overrun;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // reference model state
   cmd_t          cmd_q[$];
   pix_t          slot_q[$];
   logic          m_scr_q = 1'b0;
   logic          m_fs = 1'b0;
   logic          m_ovr = 1'b0;
   logic [CW-1:0] m_x = '0;
   logic [CW-1:0] m_y = '0;
   logic [1:0]    m_pal = 2'd0;

   log_t plog[$];
   int   fs_log[$];

   rect_rasterizer dut (
      .clk_33m(clk_33m), .rst_n(rst_n), .rst_screen_33m(rst_screen_33m),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_palette(cmd_palette),
      .write_x(write_x), .write_y(write_y), .write_palette(write_palette),
      .busy(busy), .frame_start(frame_start), .overrun(overrun)
   );

   initial forever #5 clk_33m = ~clk_33m;
   initial forever begin
      @(posedge clk_33m);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tmo(input string name);
      total++;
      bad++;
      $display("FAIL %s: bounded wait expired (cycle %0d)", name, cyc);
   endtask

   // A command costs one pop cycle and one clip cycle, then one cycle per clipped pixel.
   task automatic expand(input cmd_t c);
      int xe;
      int ye;
      slot_q.push_back('{x: '0, y: '0, pal: 2'd0});
      if (c.pal == 2'd0 || c.w == '0 || c.h == '0 || int'(c.x) >= 1280 || int'(c.y) >= 300) return;
      xe = int'(c.x) + int'(c.w);
      if (xe > 1280) xe = 1280;
      ye = int'(c.y) + int'(c.h);
      if (ye > 300) ye = 300;
      for (int yy = int'(c.y); yy < ye; yy++)
         for (int xx = int'(c.x); xx < xe; xx++)
            slot_q.push_back('{x: CW'(xx), y: CW'(yy), pal: c.pal});
   endtask

   initial forever begin
      @(posedge clk_33m or negedge rst_n);
      if (!rst_n) begin
         cmd_q.delete();
         slot_q.delete();
         m_scr_q = 1'b0; m_fs = 1'b0; m_ovr = 1'b0;
         m_x = '0; m_y = '0; m_pal = 2'd0;
      end else begin
         bit   ready_pre;
         bit   busy_pre;
         pix_t p;
         ready_pre = (cmd_q.size() < 8) && !rst_screen_33m;
         busy_pre  = (cmd_q.size() != 0) || (slot_q.size() != 0);
         m_fs  = !rst_screen_33m && m_scr_q;
         m_pal = 2'd0;
         if (rst_screen_33m && !m_scr_q) begin
            if (busy_pre) m_ovr = 1'b1;
            cmd_q.delete();
            slot_q.delete();
         end else if (!rst_screen_33m) begin
            if (slot_q.size() != 0) begin
               p = slot_q.pop_front();
               m_pal = p.pal;
               if (p.pal != 2'd0) begin
                  m_x = p.x;
                  m_y = p.y;
               end
            end else if (cmd_q.size() != 0) begin
               expand(cmd_q.pop_front());
            end
         end
         if (cmd_valid && ready_pre)
            cmd_q.push_back('{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, pal: cmd_palette});
         m_scr_q = rst_screen_33m;
      end
   end

   initial forever begin
      @(negedge clk_33m);
      if (chk_en) begin
         chk("write_palette", write_palette, m_pal);
         chk("write_x", write_x, m_x);
         chk("write_y", write_y, m_y);
         chk("busy", busy, (cmd_q.size() != 0) || (slot_q.size() != 0));
         chk("cmd_ready", cmd_ready, (cmd_q.size() < 8) && !rst_screen_33m);
         chk("frame_start", frame_start, m_fs);
         chk("overrun", overrun, m_ovr);
         if (write_palette != 2'd0)
            plog.push_back('{x: int'(write_x), y: int'(write_y), pal: int'(write_palette), cyc: cyc});
         if (frame_start) fs_log.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_33m);
         #1;
      end
   endtask

   task automatic send(input int x, input int y, input int w, input int h, input int pal, output int acc);
      bit rdy;
      int guard;
      cmd_x = CW'(x); cmd_y = CW'(y); cmd_w = CW'(w); cmd_h = CW'(h); cmd_palette = 2'(pal);
      cmd_valid = 1'b1;
      guard = 0;
      acc = -1;
      while (acc < 0) begin
         @(negedge clk_33m);
         rdy = cmd_ready;
         @(posedge clk_33m);
         #1;
         if (rdy) acc = cyc;
         else if (++guard > 6000) begin
            tmo("send_timeout");
            acc = cyc;
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      do begin
         tick(1);
         g++;
      end while (busy !== 1'b0 && g < 6000);
      if (busy !== 1'b0) tmo("idle_timeout");
      tick(2);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_write_x"}, write_x, 0);
      chk({tag, "_write_y"}, write_y, 0);
      chk({tag, "_write_palette"}, write_palette, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: run did not finish, total=%0d", total);
      $fatal(1);
   end

   initial begin
      int a;
      int a2;
      int fall;
      @(posedge clk_33m);
      #1;
      chk_en = 1'b1;
      @(negedge clk_33m);
      chk_reset_vals("reset");
      tick(1);
      rst_n = 1'b1;
      tick(2);

      // basic 3x2 rectangle
      plog.delete();
      send(10, 20, 3, 2, 2, a);
      wait_idle();
      chk("t1_count", plog.size(), 6);
      if (plog.size() == 6) begin
         chk("t1_latency", plog[0].cyc - a, 3);
         for (int i = 0; i < 6; i++) begin
            chk("t1_x", plog[i].x, 10 + i % 3);
            chk("t1_y", plog[i].y, 20 + i / 3);
            chk("t1_pal", plog[i].pal, 2);
            chk("t1_consecutive", plog[i].cyc, plog[0].cyc + i);
         end
      end
      chk("t1_idle_pal", write_palette, 0);
      chk("t1_idle_busy", busy, 0);

      // corner clip
      plog.delete();
      send(1278, 299, 5, 5, 1, a);
      wait_idle();
      chk("t2_count", plog.size(), 2);
      if (plog.size() == 2) begin
         chk("t2_p0_x", plog[0].x, 1278);
         chk("t2_p0_y", plog[0].y, 299);
         chk("t2_p1_x", plog[1].x, 1279);
         chk("t2_p1_y", plog[1].y, 299);
      end

      // dropped commands followed by a 1x1 pixel
      plog.delete();
      send(5, 5, 0, 4, 1, a);
      send(5, 5, 4, 4, 0, a2);
      send(1300, 5, 4, 4, 1, a2);
      send(0, 0, 1, 1, 3, a2);
      wait_idle();
      chk("t3_count", plog.size(), 1);
      if (plog.size() == 1) begin
         chk("t3_x", plog[0].x, 0);
         chk("t3_y", plog[0].y, 0);
         chk("t3_pal", plog[0].pal, 3);
         chk("t3_latency", plog[0].cyc - a, 9);
      end

      // fill the queue behind a large rectangle
      plog.delete();
      send(0, 0, 40, 10, 1, a);
      for (int i = 0; i < 8; i++) send(100 + 3 * i, 50, 2, 1, 2, a2);
      @(negedge clk_33m);
      chk("t4_full_ready", cmd_ready, 0);
      send(200, 60, 2, 1, 3, a2);
      wait_idle();
      chk("t4_count", plog.size(), 418);
      if (plog.size() == 418) begin
         chk("t4_gap", plog[400].cyc - plog[399].cyc, 3);
         chk("t4_first_small_x", plog[400].x, 100);
         chk("t4_last_x", plog[417].x, 201);
         chk("t4_last_pal", plog[417].pal, 3);
      end

      // swap window mid-rectangle with commands queued
      plog.delete();
      fs_log.delete();
      send(100, 100, 50, 10, 2, a);
      for (int i = 0; i < 3; i++) send(10 * i, 0, 2, 2, 1, a2);
      tick(15);
      rst_screen_33m = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t5_win_pal", write_palette, 0);
         chk("t5_win_busy", busy, 0);
         chk("t5_overrun", overrun, 1);
      end
      rst_screen_33m = 1'b0;
      fall = cyc;
      tick(4);
      chk("t5_fs_count", fs_log.size(), 1);
      if (fs_log.size() == 1) chk("t5_fs_cycle", fs_log[0], fall + 1);
      send(0, 0, 2, 2, 1, a);
      wait_idle();

      // asynchronous reset mid-draw
      send(0, 0, 100, 5, 1, a);
      tick(20);
      rst_n = 1'b0;
      @(negedge clk_33m);
      chk_reset_vals("t6");
      tick(2);
      rst_n = 1'b1;
      tick(1);
      plog.delete();
      send(5, 6, 1, 1, 1, a);
      wait_idle();
      chk("t6_count", plog.size(), 1);
      if (plog.size() == 1) begin
         chk("t6_latency", plog[0].cyc - a, 3);
         chk("t6_x", plog[0].x, 5);
         chk("t6_y", plog[0].y, 6);
      end

      // randomized commands and swap windows
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 14) == 0) begin
            rst_screen_33m = 1'b1;
            tick($urandom_range(1, 6));
            rst_screen_33m = 1'b0;
            tick(1);
         end else begin
            int rx;
            int ry;
            int rw;
            int rh;
            int rp;
            rx = ($urandom_range(0, 3) == 0) ? $urandom_range(1250, 2047) : $urandom_range(0, 1279);
            ry = ($urandom_range(0, 3) == 0) ? $urandom_range(280, 2047) : $urandom_range(0, 299);
            rw = $urandom_range(0, 30);
            rh = $urandom_range(0, 8);
            rp = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) begin
               rx = $urandom_range(1200, 1279);
               rw = $urandom_range(100, 2047);
               rh = $urandom_range(1, 2);
            end
            send(rx, ry, rw, rh, rp, a);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 5));
         end
      end
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
